alu4_chain_seq: RTL and testbench
=================================

// Module: alu4_chain_seq
// PURPOSE
//  Multi-cycle sequencer that computes a 4*NIBBLES-bit operation on one shared 4-bit
//  ALU slice (alu4: A,B,C1 in; O opcode; S,C2 out). It processes one nibble per cycle,
//  LSB first, and feeds each slice's carry-out (C2) into the next slice's carry-in (C1).
//  It sits between a requester (start/done handshake) and the alu4 instance, which it owns.
// PARAMETERS
//  NIBBLES  4  number of 4-bit slices per operation; operand width W = 4*NIBBLES (>=2)
// PORTS
//  clk     in   1   rising-edge clock
//  rst     in   1   asynchronous, active-high reset
//  start   in   1   request; sampled only in IDLE or DONE
//  op      in   2   ALU opcode; latched at start, driven unchanged on alu_o
//  a       in   W   operand A; latched at start
//  b       in   W   operand B; latched at start
//  cin     in   1   carry into nibble 0; latched at start
//  busy    out  1   high while slices are being processed (RUN)
//  done    out  1   one-cycle pulse: result/cout valid
//  result  out  W   assembled S nibbles; held until next accepted start
//  cout    out  1   C2 of the last nibble; held with result
//  alu_a   out  4   nibble idx of latched A
//  alu_b   out  4   nibble idx of latched B
//  alu_c1  out  1   carry register (cin for idx 0, previous C2 after that)
//  alu_o   out  2   latched op
//  alu_s   in   4   ALU sum/result, combinational from alu_* outputs
//  alu_c2  in   1   ALU carry-out
// BEHAVIOUR
//  - Reset (async, any time): state=IDLE, idx=0, carry=0, latches=0; busy=0, done=0,
//    result=0, cout=0, alu_a/alu_b/alu_c1/alu_o=0. Reset mid-RUN aborts with no done.
//  - FSM: IDLE -> RUN on start. RUN -> RUN while idx<NIBBLES-1. RUN -> DONE at the edge
//    that captures nibble NIBBLES-1. DONE -> RUN if start is high, else -> IDLE.
//  - Accept edge k (start=1 in IDLE/DONE): latch op,a,b,cin; set idx=0, carry=cin;
//    clear result and cout.
//  - RUN, each edge: result[4*idx+:4] <= alu_s; carry <= alu_c2; idx <= idx+1.
//    On the last nibble: cout <= alu_c2 and idx returns to 0.
//  - Timing: RUN spans edges k+1..k+NIBBLES. busy=1 between edge k and edge k+NIBBLES.
//    done=1 during the cycle after edge k+NIBBLES. Latency is NIBBLES+1 cycles from the
//    accept edge to the done cycle. Throughput is one operation per NIBBLES+1 cycles
//    (back-to-back starts are accepted in DONE).
//  - start while busy: ignored. Inputs a/b/op/cin may change freely after the accept edge.
//  - alu_* outputs are registered/decoded from latched state and are valid for the whole
//    RUN cycle. In IDLE they are driven to 0. In DONE they hold the last nibble's values.
//  - Carry is chained for every opcode. Whether C1/C2 are meaningful is the ALU's
//    concern, per opcode.
//  - idx width is clog2(NIBBLES); idx never exceeds NIBBLES-1.
// TESTING (bench drives the alu_* ports from a behavioural alu4 model with O=00 meaning
//  {C2,S}=A+B+C1 and O=01 meaning S=A&B, C2=0; NIBBLES=4)
//  1 op=00, a=16'h0FFF, b=16'h0001, cin=0 -> done 5 cycles after accept;
//    result=16'h1000, cout=0; alu_c1 seen as 0,1,1,1.
//  2 op=00, a=16'hFFFF, b=16'h0000, cin=1 -> result=16'h0000, cout=1; busy high for
//    exactly 4 cycles.
//  3 op=01, a=16'hF0F0, b=16'hFF00 -> result=16'hF000, cout=0; alu_o=01 throughout RUN.
//  4 start held high continuously, operands (1,2) then (3,4), op=00 -> done pulses
//    5 cycles apart; results 3 then 7; start pulses during busy have no effect.
//  5 rst asserted mid-RUN (after 2 nibbles) -> busy, done, result, alu_* go to 0
//    immediately; no done pulse; a new start then completes normally.
//  6 after done with no new start -> state IDLE; result and cout remain stable
//    for 20 cycles.

Source files
------------

// File: rtl/alu4_chain_seq_if.sv
// Requester and ALU-slice signals of alu4_chain_seq, bundled into one interface.
// The slave modport is the sequencer. The master modport is the requester plus the alu4 slice.
interface alu4_chain_seq_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic [3:0]   alu_a;
    logic [3:0]   alu_b;
    logic         alu_c1;
    logic [1:0]   alu_o;
    logic [3:0]   alu_s;
    logic         alu_c2;

    modport master (
        output start, op, a, b, cin, alu_s, alu_c2,
        input  busy, done, result, cout, alu_a, alu_b, alu_c1, alu_o
    );

    modport slave (
        input  start, op, a, b, cin, alu_s, alu_c2,
        output busy, done, result, cout, alu_a, alu_b, alu_c1, alu_o
    );
endinterface

// File: rtl/alu4_chain_seq.sv
// Runs a 4*NIBBLES-bit operation through one shared 4-bit ALU slice.
// Nibbles are processed LSB first, and the carry ripples from one slice to the next, one slice per cycle.
//   state | meaning
//   IDLE  | waiting for start; alu_* driven to 0
//   RUN   | one nibble captured per edge, idx = nibble on the ALU
//   DONE  | done pulse cycle; result/cout valid; start re-accepted here
module alu4_chain_seq #(
    parameter int NIBBLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    alu4_chain_seq_if.slave  bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d, idx_nxt;
    logic [IW+1:0] sh_cur, sh_nxt;
    logic [W-1:0]  a_q, a_d, b_q, b_d;
    logic [1:0]    op_q, op_d;
    logic          carry_q, carry_d;
    logic [W-1:0]  result_q, result_d;
    logic          cout_q, cout_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [3:0]    alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [1:0]    alu_o_q, alu_o_d;
    logic          last_nib;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        carry_d  = carry_q;
        result_d = result_q;
        cout_d   = cout_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        alu_o_d  = alu_o_q;
        idx_nxt  = idx_q + IW'(1);
        sh_cur   = {idx_q, 2'b00};
        sh_nxt   = {idx_nxt, 2'b00};
        last_nib = (idx_q == IW'(NIBBLES - 1));

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d  = RUN;
                    idx_d    = '0;
                    a_d      = bus.a;
                    b_d      = bus.b;
                    op_d     = bus.op;
                    carry_d  = bus.cin;
                    result_d = '0;
                    cout_d   = 1'b0;
                    busy_d   = 1'b1;
                    alu_a_d  = bus.a[3:0];
                    alu_b_d  = bus.b[3:0];
                    alu_o_d  = bus.op;
                end else begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    carry_d = 1'b0;
                    alu_a_d = '0;
                    alu_b_d = '0;
                    alu_o_d = '0;
                end
            end
            RUN: begin
                result_d = (result_q & ~(W'(4'hF) << sh_cur)) | (W'(bus.alu_s) << sh_cur);
                if (last_nib) begin
                    // carry and alu_* keep the last nibble's values through DONE
                    state_d = DONE;
                    idx_d   = '0;
                    cout_d  = bus.alu_c2;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    idx_d   = idx_nxt;
                    carry_d = bus.alu_c2;
                    alu_a_d = 4'(a_q >> sh_nxt);
                    alu_b_d = 4'(b_q >> sh_nxt);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_o_q  <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_o_q  <= alu_o_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.cout   = cout_q;
    assign bus.alu_a  = alu_a_q;
    assign bus.alu_b  = alu_b_q;
    assign bus.alu_c1 = carry_q;
    assign bus.alu_o  = alu_o_q;
endmodule

// File: tb/tb_alu4_chain_seq.sv
// Bench for alu4_chain_seq. A behavioural alu4 slice drives the alu_* inputs.
// A cycle-phase model is checked every cycle, and directed vectors add hand-computed literals.
module tb_alu4_chain_seq;
    localparam int N = 4;
    localparam int W = 4 * N;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu4_chain_seq_if #(.NIBBLES(N)) bus();
    alu4_chain_seq #(.NIBBLES(N)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // behavioural alu4 slice
    logic [4:0] alu_t;
    always_comb begin
        alu_t = '0;
        case (bus.alu_o)
            2'b00:   alu_t = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {4'b0, bus.alu_c1};
            2'b01:   alu_t = {1'b0, bus.alu_a & bus.alu_b};
            2'b10:   alu_t = {1'b0, bus.alu_a | bus.alu_b};
            default: alu_t = {1'b0, bus.alu_a ^ bus.alu_b};
        endcase
        bus.alu_s  = alu_t[3:0];
        bus.alu_c2 = alu_t[4];
    end

    function automatic logic [W:0] full_fn(input logic [1:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic cin);
        case (op)
            2'b00:   return {1'b0, a} + {1'b0, b} + (W+1)'(cin);
            2'b01:   return {1'b0, a & b};
            2'b10:   return {1'b0, a | b};
            default: return {1'b0, a ^ b};
        endcase
    endfunction

    // Model: phase 0 = idle, 1..N = RUN cycle (nibble phase-1 on the ALU), N+1 = done cycle
    int           phase = 0;
    logic [1:0]   m_op;
    logic [W-1:0] m_a, m_b;
    logic         m_cin;
    logic [W:0]   m_full;
    logic [W-1:0] hold_res;
    logic         hold_cout;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            phase     <= 0;
            m_op      <= '0;
            m_a       <= '0;
            m_b       <= '0;
            m_cin     <= 1'b0;
            m_full    <= '0;
            hold_res  <= '0;
            hold_cout <= 1'b0;
        end else if ((phase == 0 || phase == N + 1) && bus.start) begin
            m_op      <= bus.op;
            m_a       <= bus.a;
            m_b       <= bus.b;
            m_cin     <= bus.cin;
            m_full    <= full_fn(bus.op, bus.a, bus.b, bus.cin);
            hold_res  <= '0;
            hold_cout <= 1'b0;
            phase     <= 1;
        end else if (phase >= 1 && phase < N) begin
            phase <= phase + 1;
        end else if (phase == N) begin
            phase     <= N + 1;
            hold_res  <= m_full[W-1:0];
            hold_cout <= m_full[W];
        end else begin
            phase <= 0;
        end
    end

    function automatic logic carry_into(input int j);
        logic [31:0] mk;
        logic [31:0] s;
        if (j == 0) return m_cin;
        if (m_op != 2'b00) return 1'b0;
        mk = (32'd1 << (4 * j)) - 32'd1;
        s  = ({16'b0, m_a} & mk) + ({16'b0, m_b} & mk) + {31'b0, m_cin};
        return s[4 * j];
    endfunction

    always @(negedge clk) begin : cmp
        int j;
        logic [31:0] mk;
        check("busy", bus.busy, (phase >= 1 && phase <= N));
        check("done", bus.done, (phase == N + 1));
        if (phase == 0) begin
            check("idle_result", bus.result, hold_res);
            check("idle_cout", bus.cout, hold_cout);
            check("idle_alu_a", bus.alu_a, 0);
            check("idle_alu_b", bus.alu_b, 0);
            check("idle_alu_c1", bus.alu_c1, 0);
            check("idle_alu_o", bus.alu_o, 0);
        end else if (phase <= N) begin
            j  = phase - 1;
            mk = (32'd1 << (4 * j)) - 32'd1;
            check("run_result", bus.result, m_full[W-1:0] & mk[W-1:0]);
            check("run_cout", bus.cout, 0);
            check("run_alu_a", bus.alu_a, 4'(m_a >> (4 * j)));
            check("run_alu_b", bus.alu_b, 4'(m_b >> (4 * j)));
            check("run_alu_c1", bus.alu_c1, carry_into(j));
            check("run_alu_o", bus.alu_o, m_op);
        end else begin
            check("done_result", bus.result, hold_res);
            check("done_cout", bus.cout, hold_cout);
            check("done_alu_a", bus.alu_a, 4'(m_a >> (4 * (N - 1))));
            check("done_alu_b", bus.alu_b, 4'(m_b >> (4 * (N - 1))));
            check("done_alu_o", bus.alu_o, m_op);
        end
    end

    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, output logic [W-1:0] res, output logic co,
                          output int lat, output int busy_cnt, output logic [3:0] c1_seq,
                          output logic op_ok);
        @(negedge clk);
        bus.op = op; bus.a = a; bus.b = b; bus.cin = cin; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a = W'($urandom); bus.b = W'($urandom);
        bus.op = 2'($urandom); bus.cin = 1'($urandom);
        lat = 1; busy_cnt = 0; c1_seq = '0; op_ok = 1'b1;
        while (!bus.done && lat < 20) begin
            if (bus.busy) begin
                if (busy_cnt < 4) c1_seq[busy_cnt] = bus.alu_c1;
                busy_cnt++;
                if (bus.alu_o !== op) op_ok = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        res = bus.result;
        co  = bus.cout;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] res;
        logic         co;
        int           lat, bcnt, cyc, nd, ndone, bad;
        logic [3:0]   c1s;
        logic         opok;
        int           dcyc[2];
        logic [W-1:0] dres[2];

        rst = 1'b0; bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_result", bus.result, 0);
        check("reset_alu_a", bus.alu_a, 0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;

        // 1: carry ripples through three nibbles
        run_op(2'b00, 16'h0FFF, 16'h0001, 1'b0, res, co, lat, bcnt, c1s, opok);
        check("t1_latency", lat, 5);
        check("t1_result", res, 16'h1000);
        check("t1_cout", co, 0);
        check("t1_c1_seq", c1s, 4'b1110);

        // 2: carry-in propagates to carry-out
        run_op(2'b00, 16'hFFFF, 16'h0000, 1'b1, res, co, lat, bcnt, c1s, opok);
        check("t2_result", res, 16'h0000);
        check("t2_cout", co, 1);
        check("t2_busy_cycles", bcnt, 4);

        // 3: AND opcode
        run_op(2'b01, 16'hF0F0, 16'hFF00, 1'b0, res, co, lat, bcnt, c1s, opok);
        check("t3_result", res, 16'hF000);
        check("t3_cout", co, 0);
        check("t3_alu_o_held", opok, 1);

        // 4: start held high, back-to-back accepts in DONE
        @(negedge clk);
        bus.op = 2'b00; bus.a = 16'd1; bus.b = 16'd2; bus.cin = 1'b0; bus.start = 1'b1;
        cyc = 0; nd = 0;
        while (nd < 2 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin bus.a = 16'd3; bus.b = 16'd4; end
            if (bus.done) begin dcyc[nd] = cyc; dres[nd] = bus.result; nd++; end
        end
        bus.start = 1'b0;
        check("t4_done_count", nd, 2);
        if (nd == 2) begin
            check("t4_first_done", dcyc[0], 5);
            check("t4_spacing", dcyc[1] - dcyc[0], 5);
            check("t4_res0", dres[0], 16'd3);
            check("t4_res1", dres[1], 16'd7);
        end

        // 5: reset mid-RUN after two nibbles
        @(negedge clk);
        bus.op = 2'b00; bus.a = 16'h1234; bus.b = 16'h1111; bus.cin = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("t5_busy", bus.busy, 0);
        check("t5_done", bus.done, 0);
        check("t5_result", bus.result, 0);
        check("t5_alu_a", bus.alu_a, 0);
        check("t5_alu_b", bus.alu_b, 0);
        check("t5_alu_c1", bus.alu_c1, 0);
        check("t5_alu_o", bus.alu_o, 0);
        @(negedge clk);
        #2 rst = 1'b0;
        ndone = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        check("t5_no_done", ndone, 0);
        run_op(2'b00, 16'h1234, 16'h1111, 1'b0, res, co, lat, bcnt, c1s, opok);
        check("t5_restart_latency", lat, 5);
        check("t5_restart_result", res, 16'h2345);

        // 6: result/cout stable in IDLE
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.result !== 16'h2345 || bus.cout !== 1'b0 || bus.busy || bus.done) bad++;
        end
        check("t6_stable", bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
